// File: rtl/spi_master.sv
// SPI master: sends a type bit plus a 10-bit command MSB-first in one ss_n-low frame,
// and for rd-data commands captures an 8-bit reply on miso after RD_LATENCY idle cycles.
module spi_master #(
   parameter int RD_LATENCY = 2,
   parameter int IDLE_GAP   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [9:0] cmd,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [2:0] {IDLE, TYPE, SHIFT, WAIT, READ, GAP} state_t;

   localparam logic [4:0] LAT      = 5'(RD_LATENCY);
   localparam logic [4:0] LAT_END  = 5'(RD_LATENCY + 8);
   localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

   state_t     state, state_n;
   logic [9:0] shift_reg, shift_reg_n;
   logic [7:0] rx, rx_n, rd_data_n;
   logic [3:0] bit_cnt, bit_cnt_n;
   logic [4:0] lat_cnt, lat_cnt_n;
   logic       rd_cmd, rd_cmd_n;
   logic       busy_n, done_n, rd_valid_n, ss_n_n, mosi_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_reg <= '0;
         rx        <= '0;
         rd_data   <= '0;
         bit_cnt   <= '0;
         lat_cnt   <= '0;
         rd_cmd    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         ss_n      <= 1'b1;
         mosi      <= 1'b0;
      end else begin
         state     <= state_n;
         shift_reg <= shift_reg_n;
         rx        <= rx_n;
         rd_data   <= rd_data_n;
         bit_cnt   <= bit_cnt_n;
         lat_cnt   <= lat_cnt_n;
         rd_cmd    <= rd_cmd_n;
         busy      <= busy_n;
         done      <= done_n;
         rd_valid  <= rd_valid_n;
         ss_n      <= ss_n_n;
         mosi      <= mosi_n;
      end
   end

   // Every output is computed here as a next value and registered above.
   always_comb begin
      state_n     = state;
      shift_reg_n = shift_reg;
      rx_n        = rx;
      rd_data_n   = rd_data;
      bit_cnt_n   = bit_cnt;
      lat_cnt_n   = lat_cnt;
      rd_cmd_n    = rd_cmd;
      busy_n      = busy;
      ss_n_n      = ss_n;
      mosi_n      = 1'b0;
      done_n      = 1'b0;
      rd_valid_n  = 1'b0;
      case (state)
         IDLE: begin
            busy_n = 1'b0;
            ss_n_n = 1'b1;
            if (start && !busy) begin
               state_n     = TYPE;
               shift_reg_n = cmd;
               rd_cmd_n    = (cmd[9:8] == 2'b11);
               busy_n      = 1'b1;
               ss_n_n      = 1'b0;
               mosi_n      = cmd[9];
            end
         end
         TYPE: begin
            mosi_n      = shift_reg[9];
            shift_reg_n = {shift_reg[8:0], 1'b0};
            bit_cnt_n   = '0;
            state_n     = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt == 4'd9) begin
               bit_cnt_n = '0;
               lat_cnt_n = 5'd1;
               if (rd_cmd) begin
                  // Zero latency: the slave's first reply bit is already on miso.
                  if (LAT == 5'd0) begin
                     rx_n    = {rx[6:0], miso};
                     state_n = READ;
                  end else begin
                     state_n = WAIT;
                  end
               end else begin
                  ss_n_n  = 1'b1;
                  done_n  = 1'b1;
                  state_n = GAP;
               end
            end else begin
               mosi_n      = shift_reg[9];
               shift_reg_n = {shift_reg[8:0], 1'b0};
               bit_cnt_n   = bit_cnt + 4'd1;
            end
         end
         WAIT: begin
            lat_cnt_n = lat_cnt + 5'd1;
            if (lat_cnt == LAT) begin
               rx_n    = {rx[6:0], miso};
               state_n = READ;
            end
         end
         READ: begin
            if (lat_cnt == LAT_END) begin
               ss_n_n     = 1'b1;
               rd_data_n  = rx;
               rd_valid_n = 1'b1;
               done_n     = 1'b1;
               bit_cnt_n  = '0;
               state_n    = GAP;
            end else begin
               rx_n      = {rx[6:0], miso};
               lat_cnt_n = lat_cnt + 5'd1;
            end
         end
         GAP: begin
            ss_n_n = 1'b1;
            if (bit_cnt == GAP_LAST) begin
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               bit_cnt_n = bit_cnt + 4'd1;
            end
         end
         default: begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            ss_n_n    = 1'b1;
            rd_data_n = '0;
            bit_cnt_n = '0;
            lat_cnt_n = '0;
            rd_cmd_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two builds (RD_LATENCY=2/IDLE_GAP=1 and RD_LATENCY=0/IDLE_GAP=3)
// share start/cmd; a frame-level model predicts every output each cycle, plus directed literal checks.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] cmd = '0;
   logic [1:0] busy, done, rd_valid, ss_n, mosi;
   logic [1:0] miso = '0;
   logic [7:0] rd_data [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_master #(.RD_LATENCY(2), .IDLE_GAP(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
      .busy(busy[0]), .done(done[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
      .ss_n(ss_n[0]), .mosi(mosi[0]), .miso(miso[0]));

   spi_master #(.RD_LATENCY(0), .IDLE_GAP(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
      .busy(busy[1]), .done(done[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
      .ss_n(ss_n[1]), .mosi(mosi[1]), .miso(miso[1]));

   // Frame model: k = edges since acceptance; outputs follow from the frame timeline.
   bit         act [2];
   bit         rdc [2];
   int         k   [2];
   logic [9:0] mcmd [2];
   logic [7:0] rep  [2];
   logic [7:0] exp_rd [2];
   bit         force_rep = 0;
   logic [7:0] frep = '0;
   bit         rnd_en = 0;

   function automatic int lat(input int i);
      return (i == 0) ? 2 : 0;
   endfunction
   function automatic int gapc(input int i);
      return (i == 0) ? 1 : 3;
   endfunction
   function automatic int flen(input int i);
      return rdc[i] ? 19 + lat(i) : 11;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            act[i] = 0; k[i] = 0; exp_rd[i] = '0;
         end else begin
            if (act[i]) begin
               k[i]++;
               if (k[i] > flen(i) + gapc(i)) act[i] = 0;
            end
            if (!act[i] && start) begin
               act[i]  = 1;
               k[i]    = 0;
               mcmd[i] = cmd;
               rdc[i]  = (cmd[9:8] == 2'b11);
               rep[i]  = force_rep ? frep : 8'($urandom);
            end
            if (act[i] && rdc[i] && k[i] == flen(i)) exp_rd[i] = rep[i];
         end
      end
   end

   // Slave stand-in: reply bits only on the sampling edges, noise everywhere else.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int kk;
         kk = k[i] + 1;
         if (act[i] && rdc[i] && kk >= 11 + lat(i) && kk <= 18 + lat(i))
            miso[i] = rep[i][18 + lat(i) - kk];
         else
            miso[i] = 1'($urandom);
      end
   end

   always @(negedge clk) begin : cmp
      logic e_ss, e_mo, e_bz, e_dn, e_rv;
      int   f;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            e_ss = 1'b1; e_mo = 1'b0; e_bz = 1'b0; e_dn = 1'b0; e_rv = 1'b0;
            if (act[i]) begin
               f    = flen(i);
               e_ss = (k[i] >= f);
               if (k[i] == 0)       e_mo = mcmd[i][9];
               else if (k[i] <= 10) e_mo = mcmd[i][10 - k[i]];
               e_bz = (k[i] < f + gapc(i));
               e_dn = (k[i] == f);
               e_rv = rdc[i] && (k[i] == f);
            end
            total++;
            if ({ss_n[i], mosi[i], busy[i], done[i], rd_valid[i], rd_data[i]} !==
                {e_ss, e_mo, e_bz, e_dn, e_rv, exp_rd[i]}) begin
               bad++;
               $display("FAIL model[%0d] k=%0d got ss/mosi/busy/done/rv=%b%b%b%b%b rd=%h want %b%b%b%b%b rd=%h",
                        i, k[i], ss_n[i], mosi[i], busy[i], done[i], rd_valid[i], rd_data[i],
                        e_ss, e_mo, e_bz, e_dn, e_rv, exp_rd[i]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rnd_en) begin
         start = (($urandom % 3) == 0);
         cmd   = 10'($urandom);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, exp);
      end
   endtask

   logic [31:0] ss_a, mo_a, mo_b, dn_a, dn_b, rv_a, bz_a, bz_b;
   logic [7:0]  rd_a [32];
   logic [7:0]  rd_b [32];

   // One start pulse (or held start with cmd switched to c2), then record nk cycles after T.
   task automatic frame(input logic [9:0] c, input logic [7:0] r, input int nk,
                        input bit hold, input logic [9:0] c2);
      force_rep = 1; frep = r;
      @(negedge clk); start = 1'b1; cmd = c;
      @(negedge clk);
      if (hold) cmd = c2;
      else begin start = 1'b0; cmd = 10'($urandom); end
      ss_a = '0; mo_a = '0; mo_b = '0; dn_a = '0; dn_b = '0; rv_a = '0; bz_a = '0; bz_b = '0;
      for (int kk = 0; kk < nk; kk++) begin
         ss_a[kk] = ss_n[0]; mo_a[kk] = mosi[0]; mo_b[kk] = mosi[1];
         dn_a[kk] = done[0]; dn_b[kk] = done[1]; rv_a[kk] = rd_valid[0];
         bz_a[kk] = busy[0]; bz_b[kk] = busy[1];
         rd_a[kk] = rd_data[0]; rd_b[kk] = rd_data[1];
         if (kk < nk - 1) @(negedge clk);
      end
      start = 1'b0;
      force_rep = 0;
   endtask

   initial begin
      @(negedge clk);
      chk("reset ss_n", 32'(ss_n), 32'h3);
      chk("reset mosi/busy/done/rv", 32'({mosi, busy, done, rd_valid}), 32'h0);
      chk("reset rd_data", 32'({rd_data[0], rd_data[1]}), 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // write address 0x05
      frame(10'b00_0000_0101, 8'h00, 14, 0, '0);
      chk("t1 mosi_a", mo_a[10:0], 32'h500);
      chk("t1 mosi_b", mo_b[10:0], 32'h500);
      chk("t1 mosi tail", mo_a[13:11], 32'h0);
      chk("t1 ss_n", ss_a[13:0], 32'h3800);
      chk("t1 done_a", dn_a[13:0], 32'h0800);
      chk("t1 done_b", dn_b[13:0], 32'h0800);
      chk("t1 rv_a", rv_a[13:0], 32'h0);
      chk("t1 busy_a", bz_a[13:0], 32'h0FFF);
      chk("t1 busy_b", bz_b[13:0], 32'h3FFF);
      repeat (30) @(negedge clk);

      // read data, reply A5: latency 2 on dut_a, latency 0 on dut_b
      frame(10'b11_0000_0000, 8'hA5, 24, 0, '0);
      chk("t2 mosi_a", mo_a[23:0], 32'h7);
      chk("t2 done_a", dn_a[23:0], 32'h200000);
      chk("t2 rv_a", rv_a[23:0], 32'h200000);
      chk("t2 ss_a", ss_a[23:0], 32'hE00000);
      chk("t2 rd_a@20", 32'(rd_a[20]), 32'h00);
      chk("t2 rd_a@21", 32'(rd_a[21]), 32'hA5);
      chk("t6 done_b", dn_b[23:0], 32'h080000);
      chk("t6 rd_b@18", 32'(rd_b[18]), 32'h00);
      chk("t6 rd_b@19", 32'(rd_b[19]), 32'hA5);
      chk("t6 busy_b", bz_b[23:0], 32'h3FFFFF);
      repeat (30) @(negedge clk);

      // start held high across a frame while cmd switches
      frame(10'b01_1111_0000, 8'h00, 16, 1, 10'b10_0000_0001);
      chk("t3 ss_a", ss_a[15:10], 32'b000110);
      chk("t3 mosi next", mo_a[15:13], 32'b011);
      chk("t3 done_a", dn_a[15:0], 32'h0800);
      repeat (40) @(negedge clk);

      // reset mid-frame at T+5
      @(negedge clk); start = 1'b1; cmd = 10'h0AA;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4 ss_n", 32'(ss_n), 32'h3);
      chk("t4 mosi/busy/done", 32'({mosi, busy, done}), 32'h0);
      chk("t4 rd_data", 32'({rd_data[0], rd_data[1]}), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      frame(10'b10_1100_1010, 8'h00, 14, 0, '0);
      chk("t4 fresh mosi", mo_a[10:0], 32'h29B);
      chk("t4 fresh done", dn_a[13:0], 32'h0800);
      repeat (30) @(negedge clk);

      rnd_en = 1;
      repeat (4000) @(negedge clk);
      rnd_en = 0;
      start = 1'b0;
      repeat (40) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
